// File: rtl/attribute_serializer_pkg.sv
// Shared constants for the attribute path: type codes, character widths, ASCII
// punctuation and the serializer state encoding.
package attribute_serializer_pkg;

  localparam int unsigned CHAR_BITS           = 8;
  localparam int unsigned ATTRIBUTE_TYPE_BITS = 4;

  typedef logic [ATTRIBUTE_TYPE_BITS-1:0] att_type_t;
  typedef logic [CHAR_BITS-1:0]           char_t;

  localparam att_type_t ATT_COLOR      = 4'd0;
  localparam att_type_t ATT_SIZE       = 4'd1;
  localparam att_type_t ATT_WIDTH      = 4'd2;
  localparam att_type_t ATT_HEIGHT     = 4'd3;
  localparam att_type_t ATT_SRC        = 4'd4;
  localparam att_type_t ATT_HREF       = 4'd5;
  localparam att_type_t ATT_BACKGROUND = 4'd6;
  localparam att_type_t ATT_PADDING    = 4'd7;
  localparam att_type_t ATT_MARGIN     = 4'd8;
  localparam att_type_t ATT_BORDER     = 4'd9;
  localparam att_type_t ATT_POSITION   = 4'd10;

  localparam char_t ASCII_EQ    = 8'h3D;
  localparam char_t ASCII_QUOTE = 8'h22;
  localparam char_t ASCII_ZERO  = 8'h30;

  typedef enum logic [2:0] {
    StIdle,
    StName,
    StEq,
    StOpenQ,
    StDigits,
    StCloseQ,
    StDone
  } state_t;

  function automatic logic is_known_type(input att_type_t t);
    return t <= ATT_POSITION;
  endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter: one input bit per cycle, add-3 on each
// nibble >= 5 before the shift. done stays high until the next start.
module bin_to_bcd #(
  parameter int unsigned VAL_BITS   = 16,
  parameter int unsigned MAX_DIGITS = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [VAL_BITS-1:0]     value,
  output logic                    done,
  output logic [4*MAX_DIGITS-1:0] bcd
);

  localparam int unsigned CntBits = $clog2(VAL_BITS + 1);

  logic [VAL_BITS-1:0]     shift_q;
  logic [CntBits-1:0]      cnt_q;
  logic [4*MAX_DIGITS-1:0] bcd_q;
  logic [4*MAX_DIGITS-1:0] bcd_adj;
  logic                    done_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else if (start) begin
      shift_q <= value;
      cnt_q   <= CntBits'(VAL_BITS);
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else if (cnt_q != '0) begin
      bcd_q   <= {bcd_adj[4*MAX_DIGITS-2:0], shift_q[VAL_BITS-1]};
      shift_q <= {shift_q[VAL_BITS-2:0], 1'b0};
      cnt_q   <= cnt_q - CntBits'(1);
      done_q  <= (cnt_q == CntBits'(1));
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/attribute_serializer.sv
// Emits one decoded attribute as XML text (name="value"), one character per
// valid/ready handshake. The character port is char_value since char is a keyword.
module attribute_serializer
  import attribute_serializer_pkg::*;
#(
  parameter int unsigned VAL_BITS   = 16,
  parameter int unsigned MAX_DIGITS = 5
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ATTRIBUTE_TYPE_BITS-1:0] in_type,
  input  logic [VAL_BITS-1:0]            in_value,
  output logic [CHAR_BITS-1:0]           char_value,
  output logic                           char_valid,
  input  logic                           char_ready,
  output logic                           busy,
  output logic                           has_finished,
  output logic                           error
);

  localparam int unsigned DigitIdxBits = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  // Names are right-justified in an 80-bit field; index 0 is the first letter.
  function automatic logic [79:0] name_str(input att_type_t t);
    case (t)
      ATT_COLOR:      return 80'("color");
      ATT_SIZE:       return 80'("size");
      ATT_WIDTH:      return 80'("width");
      ATT_HEIGHT:     return 80'("height");
      ATT_SRC:        return 80'("src");
      ATT_HREF:       return 80'("href");
      ATT_BACKGROUND: return 80'("background");
      ATT_PADDING:    return 80'("padding");
      ATT_MARGIN:     return 80'("margin");
      ATT_BORDER:     return 80'("border");
      ATT_POSITION:   return 80'("position");
      default:        return '0;
    endcase
  endfunction

  function automatic logic [3:0] name_len(input att_type_t t);
    case (t)
      ATT_COLOR:      return 4'd5;
      ATT_SIZE:       return 4'd4;
      ATT_WIDTH:      return 4'd5;
      ATT_HEIGHT:     return 4'd6;
      ATT_SRC:        return 4'd3;
      ATT_HREF:       return 4'd4;
      ATT_BACKGROUND: return 4'd10;
      ATT_PADDING:    return 4'd7;
      ATT_MARGIN:     return 4'd6;
      ATT_BORDER:     return 4'd6;
      ATT_POSITION:   return 4'd8;
      default:        return 4'd0;
    endcase
  endfunction

  function automatic char_t name_char(input att_type_t t, input logic [3:0] idx);
    logic [79:0] s;
    int          pos;
    s   = name_str(t);
    pos = int'(name_len(t)) - 1 - int'(idx);
    if (pos < 0) return '0;
    return s[8*pos +: 8];
  endfunction

  state_t                    state_q, state_d;
  att_type_t                 type_q, type_d;
  logic                      err_q, err_d;
  logic [3:0]                name_idx_q, name_idx_d;
  logic [DigitIdxBits-1:0]   digit_idx_q, digit_idx_d;
  logic                      started_q, started_d;

  logic                      conv_start;
  logic                      conv_done;
  logic [4*MAX_DIGITS-1:0]   bcd;
  logic [DigitIdxBits-1:0]   msd;
  logic [DigitIdxBits-1:0]   cur_digit;
  char_t                     digit_char;

  bin_to_bcd #(
    .VAL_BITS   (VAL_BITS),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_bin_to_bcd (
    .clock (clock),
    .reset (reset),
    .start (conv_start),
    .value (in_value),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Most significant non-zero digit; a value of zero yields digit 0 alone.
  always_comb begin
    msd = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msd = DigitIdxBits'(i);
    end
  end

  assign cur_digit  = started_q ? digit_idx_q : msd;
  assign digit_char = ASCII_ZERO + CHAR_BITS'(bcd[4*cur_digit +: 4]);

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    err_d       = err_q;
    name_idx_d  = name_idx_q;
    digit_idx_d = digit_idx_q;
    started_d   = started_q;
    conv_start  = 1'b0;
    char_value  = '0;
    char_valid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          conv_start = 1'b1;
          type_d     = in_type;
          err_d      = !is_known_type(in_type);
          name_idx_d = '0;
          started_d  = 1'b0;
          state_d    = is_known_type(in_type) ? StName : StDone;
        end
      end
      StName: begin
        char_valid = 1'b1;
        char_value = name_char(type_q, name_idx_q);
        if (char_ready) begin
          if (name_idx_q == name_len(type_q) - 4'd1) state_d = StEq;
          else name_idx_d = name_idx_q + 4'd1;
        end
      end
      StEq: begin
        char_valid = 1'b1;
        char_value = ASCII_EQ;
        if (char_ready) state_d = StOpenQ;
      end
      StOpenQ: begin
        char_valid = 1'b1;
        char_value = ASCII_QUOTE;
        if (char_ready) state_d = StDigits;
      end
      StDigits: begin
        char_valid = conv_done;
        if (conv_done) begin
          char_value = digit_char;
          if (char_ready) begin
            started_d = 1'b1;
            if (cur_digit == '0) state_d = StCloseQ;
            else digit_idx_d = cur_digit - DigitIdxBits'(1);
          end
        end
      end
      StCloseQ: begin
        char_valid = 1'b1;
        char_value = ASCII_QUOTE;
        if (char_ready) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      type_q      <= '0;
      err_q       <= 1'b0;
      name_idx_q  <= '0;
      digit_idx_q <= '0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      err_q       <= err_d;
      name_idx_q  <= name_idx_d;
      digit_idx_q <= digit_idx_d;
      started_q   <= started_d;
    end
  end

  assign busy         = (state_q != StIdle) && (state_q != StDone);
  assign has_finished = (state_q == StDone);
  assign error        = (state_q == StDone) && err_q;

endmodule

// File: doc/attribute_serializer.md
Name: attribute_serializer

Overview:
- Writer side of the attribute path: takes one decoded attribute (type code plus integer value) and emits its XML text form, e.g. `width="640"`, one character per handshake.
- Output is a byte stream feeding the page/tag writer.
- Type codes and spellings are the same set the attribute parser accepts, so serializer output parses back to the same type/value.

Parameters:
- VAL_BITS, 16, width of the integer value; max decimal digits = ceil(VAL_BITS*log10(2)) (5 at default).
- MAX_DIGITS, 5, BCD digit count held by the converter; must cover VAL_BITS.

Ports:
- clock  in  1  global clock, all state on posedge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  capture in_type/in_value and begin; honoured only in IDLE.
- in_type  in  `ATTRIBUTE_TYPE_BITES  attribute type code (ATT_* constants).
- in_value  in  VAL_BITS  unsigned attribute value.
- char  out  `CHAR_BITES  current ASCII character.
- char_valid  out  1  char holds a character to transfer.
- char_ready  in  1  downstream accepts char this cycle.
- busy  out  1  high from the cycle after accepted start until has_finished.
- has_finished  out  1  one-cycle pulse after the closing quote transfers (or on error).
- error  out  1  one-cycle pulse with has_finished when in_type is unknown; no characters are emitted.

Behaviour:
- Reset: char=0, char_valid=0, busy=0, has_finished=0, error=0, state=IDLE, converter cleared. Reset wins over every other input, including mid-stream; a partially sent attribute is abandoned with no closing quote.
- Transfer rule: a character moves on a posedge with char_valid && char_ready. While char_valid && !char_ready, char holds stable and char_valid stays high. char_valid never drops without a transfer, except on reset.
- States: IDLE, NAME, EQ, OPENQ, DIGITS, CLOSEQ, DONE.
- IDLE: on start, latch type and value, start the converter, set busy. Next state is NAME, or DONE with error if the type is unknown. Start in any other state is ignored.
- NAME: emit the name ROM characters for the latched type, index 0..len-1, advancing on each transfer; go to EQ after the last one. Spellings: color, size, width, height, src, href, background, padding, margin, border, position.
- EQ: emit "=". OPENQ: emit '"' (0x22).
- DIGITS:
  - char_valid stays low until the converter reports done.
  - Then emit BCD digits most-significant first, skipping leading zeros.
  - Value 0 emits the single digit "0".
  - Each digit is 0x30 + BCD nibble.
- CLOSEQ: emit '"'. After it transfers, go to DONE.
- DONE: has_finished=1 (and error=1 if applicable) for one cycle, busy=0, return to IDLE. A start in the DONE cycle is ignored.
- Latency:
  - First char_valid appears the cycle after start.
  - Conversion takes VAL_BITS cycles after start and runs concurrently with NAME/EQ/OPENQ.
  - With char_ready tied high, total cycles = 1 + name_len + 2 + max(0, VAL_BITS - (name_len+2)) + ndigits + 1 + 1.
- Arithmetic: double-dabble conversion, one bit per cycle; add 3 to each nibble >= 5 before each shift. All values are unsigned; no overflow, since MAX_DIGITS covers 2^VAL_BITS-1.

Decomposition:
- Shared constants header: ATT_* codes, `CHAR_BITES, `ATTRIBUTE_TYPE_BITES, ASCII constants for '=', '"', '0'.
- Name ROM stays local to the serializer, as a function from (type, index) to char plus a length function.
- One sub-module, bin_to_bcd:
  - Inputs: clock, reset, start, value.
  - Outputs: done, bcd[4*MAX_DIGITS].
  - Sequential shift-add-3; done holds high until the next start.

Test Plan:
- type=ATT_WIDTH, value=640, char_ready=1 -> stream w,i,d,t,h,=,",6,4,0," (11 transfers); has_finished pulses once; error=0.
- type=ATT_SIZE, value=0 -> s,i,z,e,=,",0,"; zero handled, no leading zeros. type=ATT_SRC, value=65535 -> s,r,c,=,",6,5,5,3,5,"; check the DIGITS stall until conversion done.
- Backpressure: ATT_HREF, value=7, char_ready toggled pseudo-randomly -> char stable whenever valid && !ready; stream h,r,e,f,=,",7," exactly once, no drops or duplicates.
- Unknown in_type (unused code), value=12 -> zero transfers; has_finished and error pulse together the cycle after the DONE transition; busy drops.
- Reset asserted after "pad" has transferred for ATT_PADDING -> next cycle all outputs at reset values. A new start with ATT_COLOR, 255 then yields c,o,l,o,r,=,",2,5,5,". A start asserted while busy is ignored (stream unchanged).
